// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the 5-stage MIPS pipeline front end.
//   DEFAULT_RESET_PC : PC loaded on reset unless the fetch unit overrides it
//   NOP_INSTR        : instruction word presented in ID for a bubble
//   if_id_t          : IF/ID pipeline-register bundle (instr, pc_plus4, valid)
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    // Force a branch/jump target onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with three controls, evaluated in priority order:
//   i_load   : capture i_data
//   i_hold   : keep current contents
//   i_bubble : insert a bubble (NOP_INSTR, valid=0, pc_plus4 kept)
// With no control asserted the register holds.
// Ports:
//   i_clk    in  clock, rising edge
//   i_rst_n  in  synchronous active-low reset, clears the whole bundle
//   i_load, i_hold, i_bubble  in  controls above
//   i_data   in  bundle to capture
//   o_data   out registered IF/ID bundle
// -----------------------------------------------------------------------------
module if_id_reg
    import pipeline_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_load,
    input  logic   i_hold,
    input  logic   i_bubble,
    input  if_id_t i_data,
    output if_id_t o_data
);

    if_id_t r_ifid_p1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ifid_p1 <= '0;
        end else if (i_load) begin
            r_ifid_p1 <= i_data;
        end else if (i_hold) begin
            r_ifid_p1 <= r_ifid_p1;
        end else if (i_bubble) begin
            r_ifid_p1.instr <= NOP_INSTR;
            r_ifid_p1.valid <= 1'b0;
        end
    end

    assign o_data = r_ifid_p1;

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Instruction-fetch stage: owns the PC, issues instruction-memory fetches and
// loads the IF/ID register. A redirect arriving while memory has not yet
// returned the current fetch is parked in a one-entry pending buffer and
// applied when that fetch completes; its returned instruction is discarded.
//
// Configuration macro: BRANCH_DELAY_SLOT_EN
//   defined   : FlushID tied to 0 (instruction in ID runs as the delay slot)
//   undefined : FlushID = PCSrc & ~PendValid & Rst
//
// Ports:
//   Clk          in   clock, rising edge
//   Rst          in   synchronous active-low reset
//   Stall        in   hazard stall, holds PC and IF/ID
//   PCSrc        in   redirect request
//   PCNew[31:0]  in   redirect target (low two bits ignored, flagged)
//   IMemReady    in   Instruction valid for IMemAddr this cycle
//   Instruction  in   instruction-memory read data
//   IMemReq      out  fetch request (follows Rst)
//   IMemAddr     out  current PC
//   Instr_ID     out  IF/ID instruction
//   PCPlus4_ID   out  IF/ID PC+4
//   Valid_ID     out  IF/ID holds a real instruction
//   FlushID      out  combinational squash request for ID/EX
//   AlignErr     out  one-cycle pulse for an accepted misaligned target
// -----------------------------------------------------------------------------
module pc_fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic [31:0] PCNew,
    input  logic        IMemReady,
    input  logic [31:0] Instruction,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    output logic [31:0] Instr_ID,
    output logic [31:0] PCPlus4_ID,
    output logic        Valid_ID,
    output logic        FlushID,
    output logic        AlignErr
);

    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;
    logic        r_pend_valid;
    logic        r_align_err;

    logic        w_accept;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic        w_load;
    logic        w_hold;
    logic        w_bubble;
    if_id_t      w_ifid_d;
    if_id_t      w_ifid_q;

    // A younger redirect seen while one is parked lies on the squashed path.
    assign w_accept   = PCSrc & ~r_pend_valid;
    assign w_target   = word_align(PCNew);
    assign w_pc_plus4 = r_pc + 32'd4;

    // IF/ID controls. Redirects beat Stall since the stalled ID op is wrong-path;
    // a parked redirect keeps IF/ID frozen until memory answers.
    assign w_load   = ~w_accept & ~r_pend_valid & ~Stall & IMemReady;
    assign w_hold   = r_pend_valid ? ~IMemReady : (~w_accept & Stall);
    assign w_bubble = ~w_load & ~w_hold;

    assign w_ifid_d.instr    = Instruction;
    assign w_ifid_d.pc_plus4 = w_pc_plus4;
    assign w_ifid_d.valid    = 1'b1;

    // ---- IF stage: PC and pending-redirect buffer ----
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_pc         <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
            r_align_err  <= 1'b0;
        end else begin
            r_align_err <= w_accept & (PCNew[1:0] != 2'b00);
            if (w_accept) begin
                if (IMemReady) begin
                    r_pc <= w_target;
                end else begin
                    r_pend_valid <= 1'b1;
                    r_pend_pc    <= w_target;
                end
            end else if (r_pend_valid) begin
                if (IMemReady) begin
                    r_pc         <= r_pend_pc;
                    r_pend_valid <= 1'b0;
                end
            end else if (!Stall && IMemReady) begin
                r_pc <= w_pc_plus4;
            end
        end
    end

    // ---- IF/ID boundary ----
    if_id_reg u_if_id_reg (
        .i_clk    (Clk),
        .i_rst_n  (Rst),
        .i_load   (w_load),
        .i_hold   (w_hold),
        .i_bubble (w_bubble),
        .i_data   (w_ifid_d),
        .o_data   (w_ifid_q)
    );

    assign IMemReq    = Rst;
    assign IMemAddr   = r_pc;
    assign Instr_ID   = w_ifid_q.instr;
    assign PCPlus4_ID = w_ifid_q.pc_plus4;
    assign Valid_ID   = w_ifid_q.valid;
    assign AlignErr   = r_align_err;

`ifdef BRANCH_DELAY_SLOT_EN
    assign FlushID = 1'b0;
`else
    assign FlushID = PCSrc & ~r_pend_valid & Rst;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst, Stall, PCSrc, IMemReady;
    logic [31:0] PCNew, Instruction;
    logic        IMemReq, Valid_ID, FlushID, AlignErr;
    logic [31:0] IMemAddr, Instr_ID, PCPlus4_ID;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural reference state
    logic [31:0] m_pc, m_pendpc, m_instr, m_pp4;
    logic        m_pend, m_valid, m_align;

    always #5 Clk = ~Clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .PCSrc(PCSrc), .PCNew(PCNew),
        .IMemReady(IMemReady), .Instruction(Instruction), .IMemReq(IMemReq),
        .IMemAddr(IMemAddr), .Instr_ID(Instr_ID), .PCPlus4_ID(PCPlus4_ID),
        .Valid_ID(Valid_ID), .FlushID(FlushID), .AlignErr(AlignErr)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'h1234, ~a[31:16] ^ a[15:0]};
    endfunction

    // Instruction memory: data always valid for the address on the bus.
    always_comb Instruction = mem(IMemAddr);

    function automatic logic exp_flush();
`ifdef BRANCH_DELAY_SLOT_EN
        return 1'b0;
`else
        return PCSrc && !m_pend && Rst;
`endif
    endfunction

    // Advance one clock; the reference applies the fetch rules in priority order.
    task automatic step();
        logic        acc;
        logic [31:0] tgt;
        @(posedge Clk);
        if (!Rst) begin
            m_pc = 32'h0; m_pend = 0; m_pendpc = 0;
            m_instr = 0; m_pp4 = 0; m_valid = 0; m_align = 0;
        end else begin
            acc = PCSrc && !m_pend;
            tgt = PCNew & 32'hFFFF_FFFC;
            m_align = acc && (PCNew % 4 != 0);
            if (acc) begin
                m_valid = 0; m_instr = 0;
                if (IMemReady) m_pc = tgt;
                else begin m_pend = 1; m_pendpc = tgt; end
            end else if (m_pend) begin
                if (IMemReady) begin
                    m_pc = m_pendpc; m_pend = 0; m_valid = 0; m_instr = 0;
                end
            end else if (Stall) begin
                // everything held
            end else if (IMemReady) begin
                m_instr = mem(m_pc); m_pp4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
            end else begin
                m_valid = 0; m_instr = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        Rst = 0; Stall = 0; PCSrc = 1; PCNew = 32'h80; IMemReady = 1;
        #1;
        n_total++; if (FlushID !== 1'b0) $display("FAIL reset_flush got=%b exp=0", FlushID); else n_pass++;
        step(); step();
        n_total++; if (IMemAddr !== 32'h0) $display("FAIL reset_addr got=%h exp=0", IMemAddr); else n_pass++;
        n_total++; if (IMemReq !== 1'b0) $display("FAIL reset_req got=%b exp=0", IMemReq); else n_pass++;
        n_total++; if ({Valid_ID, AlignErr} !== 2'b00) $display("FAIL reset_vld_align got=%b exp=00", {Valid_ID, AlignErr}); else n_pass++;
        n_total++; if ({Instr_ID, PCPlus4_ID} !== 64'h0) $display("FAIL reset_ifid got=%h exp=0", {Instr_ID, PCPlus4_ID}); else n_pass++;
    endtask

    task automatic test_seq_fetch();
        Rst = 1; PCSrc = 0; IMemReady = 1;
        #1;
        n_total++; if (IMemReq !== 1'b1) $display("FAIL seq_req got=%b exp=1", IMemReq); else n_pass++;
        n_total++; if (Valid_ID !== 1'b0) $display("FAIL seq_vld0 got=%b exp=0", Valid_ID); else n_pass++;
        step();
        n_total++; if (IMemAddr !== 32'h4) $display("FAIL seq_addr4 got=%h exp=4", IMemAddr); else n_pass++;
        n_total++; if (PCPlus4_ID !== 32'h4 || Valid_ID !== 1'b1) $display("FAIL seq_id1 got=%h/%b exp=4/1", PCPlus4_ID, Valid_ID); else n_pass++;
        n_total++; if (Instr_ID !== mem(32'h0)) $display("FAIL seq_instr got=%h exp=%h", Instr_ID, mem(32'h0)); else n_pass++;
        step();
        n_total++; if (IMemAddr !== 32'h8 || PCPlus4_ID !== 32'h8) $display("FAIL seq_addr8 got=%h/%h exp=8/8", IMemAddr, PCPlus4_ID); else n_pass++;
        step(); step();
        n_total++; if (IMemAddr !== 32'h10) $display("FAIL seq_addr10 got=%h exp=10", IMemAddr); else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] saved;
        saved = Instr_ID;
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (IMemAddr !== 32'h10 || Instr_ID !== saved || Valid_ID !== 1'b1)
                $display("FAIL stall_hold%0d got=%h/%h/%b exp=10/%h/1", i, IMemAddr, Instr_ID, Valid_ID, saved);
            else n_pass++;
        end
        Stall = 0;
        step();
        n_total++; if (Instr_ID !== mem(32'h10) || PCPlus4_ID !== 32'h14 || IMemAddr !== 32'h14)
            $display("FAIL stall_resume got=%h/%h/%h exp=%h/14/14", Instr_ID, PCPlus4_ID, IMemAddr, mem(32'h10));
        else n_pass++;
        step();
        n_total++; if (IMemAddr !== 32'h18) $display("FAIL stall_next got=%h exp=18", IMemAddr); else n_pass++;
    endtask

    task automatic test_redirect();
        logic exp_f;
`ifdef BRANCH_DELAY_SLOT_EN
        exp_f = 1'b0;
`else
        exp_f = 1'b1;
`endif
        PCSrc = 1; PCNew = 32'h400; IMemReady = 1;
        #1;
        n_total++; if (FlushID !== exp_f) $display("FAIL redir_flush got=%b exp=%b", FlushID, exp_f); else n_pass++;
        step();
        PCSrc = 0;
        n_total++; if (IMemAddr !== 32'h400 || Valid_ID !== 1'b0 || AlignErr !== 1'b0)
            $display("FAIL redir_target got=%h/%b/%b exp=400/0/0", IMemAddr, Valid_ID, AlignErr);
        else n_pass++;
        step();
        n_total++; if (Valid_ID !== 1'b1 || PCPlus4_ID !== 32'h404 || Instr_ID !== mem(32'h400))
            $display("FAIL redir_id got=%b/%h/%h exp=1/404/%h", Valid_ID, PCPlus4_ID, Instr_ID, mem(32'h400));
        else n_pass++;
    endtask

    task automatic test_pending();
        IMemReady = 0; PCSrc = 1; PCNew = 32'h200;
        step();
        PCNew = 32'h300;
        #1;
        n_total++; if (FlushID !== 1'b0) $display("FAIL pend_flush2 got=%b exp=0", FlushID); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            step();
            PCSrc = 0;
            n_total++; if (IMemAddr !== 32'h404 || Valid_ID !== 1'b0)
                $display("FAIL pend_wait%0d got=%h/%b exp=404/0", i, IMemAddr, Valid_ID);
            else n_pass++;
        end
        IMemReady = 1;
        step();
        n_total++; if (IMemAddr !== 32'h200 || Valid_ID !== 1'b0)
            $display("FAIL pend_apply got=%h/%b exp=200/0", IMemAddr, Valid_ID);
        else n_pass++;
        step();
        n_total++; if (Valid_ID !== 1'b1 || PCPlus4_ID !== 32'h204)
            $display("FAIL pend_load got=%b/%h exp=1/204", Valid_ID, PCPlus4_ID);
        else n_pass++;
    endtask

    task automatic test_misalign_wrap();
        PCSrc = 1; PCNew = 32'h403; IMemReady = 1;
        step();
        PCSrc = 0;
        n_total++; if (IMemAddr !== 32'h400 || AlignErr !== 1'b1)
            $display("FAIL align_set got=%h/%b exp=400/1", IMemAddr, AlignErr);
        else n_pass++;
        step();
        n_total++; if (AlignErr !== 1'b0) $display("FAIL align_clear got=%b exp=0", AlignErr); else n_pass++;
        PCSrc = 1; PCNew = 32'hFFFF_FFFC;
        step();
        PCSrc = 0;
        step();
        n_total++; if (IMemAddr !== 32'h0 || PCPlus4_ID !== 32'h0 || Valid_ID !== 1'b1 || Instr_ID !== mem(32'hFFFF_FFFC))
            $display("FAIL wrap got=%h/%h/%b/%h exp=0/0/1/%h", IMemAddr, PCPlus4_ID, Valid_ID, Instr_ID, mem(32'hFFFF_FFFC));
        else n_pass++;
    endtask

    task automatic test_reset_mid_pending();
        IMemReady = 0; PCSrc = 1; PCNew = 32'h800;
        step();
        PCSrc = 0; Rst = 0;
        step();
        n_total++; if (IMemAddr !== 32'h0 || Valid_ID !== 1'b0)
            $display("FAIL rstpend_addr got=%h/%b exp=0/0", IMemAddr, Valid_ID);
        else n_pass++;
        Rst = 1; IMemReady = 1;
        step();
        n_total++; if (IMemAddr !== 32'h4 || PCPlus4_ID !== 32'h4 || Instr_ID !== mem(32'h0))
            $display("FAIL rstpend_fetch got=%h/%h/%h exp=4/4/%h", IMemAddr, PCPlus4_ID, Instr_ID, mem(32'h0));
        else n_pass++;
        step();
        n_total++; if (IMemAddr !== 32'h8) $display("FAIL rstpend_next got=%h exp=8", IMemAddr); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            Rst       = ($urandom_range(0, 39) != 0);
            Stall     = ($urandom_range(0, 3) == 0);
            PCSrc     = ($urandom_range(0, 5) == 0);
            IMemReady = ($urandom_range(0, 2) != 0);
            PCNew     = $urandom;
            if ($urandom_range(0, 1) == 0) PCNew[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) PCNew = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            #1;
            n_total++; if (FlushID !== exp_flush()) $display("FAIL rnd_flush c%0d got=%b exp=%b", i, FlushID, exp_flush()); else n_pass++;
            n_total++; if (IMemReq !== Rst) $display("FAIL rnd_req c%0d got=%b exp=%b", i, IMemReq, Rst); else n_pass++;
            step();
            n_total++; if (IMemAddr !== m_pc) $display("FAIL rnd_addr c%0d got=%h exp=%h", i, IMemAddr, m_pc); else n_pass++;
            n_total++; if ({Valid_ID, Instr_ID, PCPlus4_ID} !== {m_valid, m_instr, m_pp4})
                $display("FAIL rnd_ifid c%0d got=%b/%h/%h exp=%b/%h/%h", i, Valid_ID, Instr_ID, PCPlus4_ID, m_valid, m_instr, m_pp4);
            else n_pass++;
            n_total++; if (AlignErr !== m_align) $display("FAIL rnd_align c%0d got=%b exp=%b", i, AlignErr, m_align); else n_pass++;
        end
    endtask

    initial begin
        m_pc = 0; m_pend = 0; m_pendpc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_align = 0;
        Rst = 0; Stall = 0; PCSrc = 0; PCNew = 0; IMemReady = 0;
        @(posedge Clk); #1;
        test_reset();
        test_seq_fetch();
        test_stall();
        test_redirect();
        test_pending();
        test_misalign_wrap();
        test_reset_mid_pending();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
